// File: rtl/fetch_prefetch_pkg.sv
// Shared fetch-side types: the CPU-wide fetch command enum and the byte-queue
// transfer record with its instruction-length helper.
package cpu_common;
    typedef enum logic [1:0] {
        FETCH_NOP    = 2'd0,
        FETCH_INC_PC = 2'd1,
        FETCH_JUMP   = 2'd2
    } fetch_operation_t;
endpackage

package fetch_prefetch_pkg;
    // n = 0, 1 or 2 bytes; data[7:0] is the lower-addressed byte
    typedef struct packed {
        logic [1:0]  n;
        logic [15:0] data;
    } byte_xfer_t;

    function automatic logic [1:0] inst_len(input logic [7:0] first_byte);
        return first_byte[1] ? 2'd2 : 2'd1;
    endfunction
endpackage

// File: rtl/fetch_prefetch_if.sv
// Instruction-memory read port: word address out, read data back one cycle later.
interface fetch_prefetch_if #(
    parameter int PC_W = 14
);
    logic [PC_W-2:0] mem_inst_addr;
    logic [15:0]     mem_instr;

    modport master (output mem_inst_addr, input mem_instr);
    modport slave  (input mem_inst_addr, output mem_instr);
endinterface

// File: rtl/fetch_byte_queue.sv
// Circular byte FIFO with up to two pushes and two pops per cycle; exposes the
// two oldest bytes as head.
module fetch_byte_queue
    import fetch_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_sync,
    input  logic                     flush,
    input  byte_xfer_t               push,
    input  logic [1:0]               pop_n,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][7:0] data_q;
    logic [AW-1:0]         rd_q, wr_q;
    logic [AW-1:0]         rd_p1, wr_p1;
    logic [CW-1:0]         cnt_q;

    assign rd_p1 = rd_q + AW'(1);
    assign wr_p1 = wr_q + AW'(1);

    always_ff @(posedge clk) begin
        if (rst_sync || flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push.n);
            rd_q  <= rd_q + AW'(pop_n);
            cnt_q <= cnt_q + CW'(push.n) - CW'(pop_n);
        end
    end

    // Storage needs no reset: bytes are only visible once counted in.
    always_ff @(posedge clk) begin
        if (push.n != 2'd0) data_q[wr_q]  <= push.data[7:0];
        if (push.n == 2'd2) data_q[wr_p1] <= push.data[15:8];
    end

    assign count = cnt_q;
    assign head  = {data_q[rd_p1], data_q[rd_q]};
endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: streams 16-bit memory words into a byte queue and
// presents a 1- or 2-byte instruction at pc, with jump flush and wrap-around.
module fetch_prefetch
    import cpu_common::*;
    import fetch_prefetch_pkg::*;
#(
    parameter int PC_W        = 14,
    parameter int QUEUE_BYTES = 4
) (
    input  logic                clk,
    input  logic                rst_sync,
    input  fetch_operation_t    fetch_operation,
    input  logic [PC_W-1:0]     jump_addr,
    output logic [15:0]         inst,
    output logic                inst_valid,
    output logic [PC_W-1:0]     pc,
    fetch_prefetch_if.master    mem_bus
);
    localparam int CW = $clog2(QUEUE_BYTES) + 1;
    localparam int SW = CW + 1;
    localparam int AW = PC_W - 1;

    logic [PC_W-1:0] pc_q, fptr_q;
    logic [AW-1:0]   addr_q;
    logic            in_flight_q, in_flight_odd_q;

    logic [CW-1:0]   count;
    logic [15:0]     head;
    logic [SW-1:0]   committed;
    logic            jump, issue, head_ok;
    logic [1:0]      pop_n;
    byte_xfer_t      push;

    fetch_byte_queue #(.DEPTH(QUEUE_BYTES)) u_queue (
        .clk      (clk),
        .rst_sync (rst_sync),
        .flush    (jump),
        .push     (push),
        .pop_n    (pop_n),
        .count    (count),
        .head     (head)
    );

    always_comb begin
        jump      = (fetch_operation == FETCH_JUMP);
        // Bytes already queued plus bytes landing this cycle bound the free space.
        committed = SW'(count);
        if (in_flight_q) committed = committed + (in_flight_odd_q ? SW'(1) : SW'(2));
        issue     = !rst_sync && !jump && (committed + SW'(2) <= SW'(QUEUE_BYTES));
        head_ok   = ((count >= CW'(1)) && !head[1]) || (count >= CW'(2));

        pop_n = 2'd0;
        if (!rst_sync && (fetch_operation == FETCH_INC_PC) && head_ok)
            pop_n = inst_len(head[7:0]);

        // A read issued from an odd fptr only contributes its upper byte.
        push.n    = 2'd0;
        push.data = mem_bus.mem_instr;
        if (in_flight_q) begin
            push.n = in_flight_odd_q ? 2'd1 : 2'd2;
            if (in_flight_odd_q) push.data = {8'h00, mem_bus.mem_instr[15:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            pc_q            <= '0;
            fptr_q          <= '0;
            addr_q          <= '0;
            in_flight_q     <= 1'b0;
            in_flight_odd_q <= 1'b0;
        end else if (jump) begin
            pc_q        <= jump_addr;
            fptr_q      <= jump_addr;
            in_flight_q <= 1'b0;
        end else begin
            pc_q        <= pc_q + PC_W'(pop_n);
            in_flight_q <= issue;
            if (issue) begin
                fptr_q          <= {fptr_q[PC_W-1:1] + AW'(1), 1'b0};
                addr_q          <= fptr_q[PC_W-1:1];
                in_flight_odd_q <= fptr_q[0];
            end
        end
    end

    assign inst                  = head;
    assign inst_valid            = !rst_sync && head_ok;
    assign pc                    = rst_sync ? '0 : pc_q;
    assign mem_bus.mem_inst_addr = rst_sync ? '0 : (issue ? fptr_q[PC_W-1:1] : addr_q);
endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: per-cycle vector table plus a queue-fill sequence.
module tb_fetch_prefetch;
    import cpu_common::*;

    typedef struct {
        logic             rst;
        fetch_operation_t op;
        logic [13:0]      ja;
        logic [13:0]      pc;
        logic             vld;
        logic [15:0]      inst;
        logic [15:0]      mask;
        logic [12:0]      addr;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_sync;
    fetch_operation_t fetch_operation;
    logic [13:0]      jump_addr;
    logic [15:0]      inst;
    logic             inst_valid;
    logic [13:0]      pc;
    logic [15:0]      mem [0:8191];
    vec_t             tbl [$];
    int               n_pass = 0;
    int               n_tot  = 0;

    fetch_prefetch_if #(.PC_W(14)) mbus ();

    fetch_prefetch #(.PC_W(14), .QUEUE_BYTES(4)) dut (
        .clk             (clk),
        .rst_sync        (rst_sync),
        .fetch_operation (fetch_operation),
        .jump_addr       (jump_addr),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .pc              (pc),
        .mem_bus         (mbus.master)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data for an address shows up the following cycle.
    always @(posedge clk) mbus.mem_instr <= mem[mbus.mem_inst_addr];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tot++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    function automatic vec_t mk(input logic r, input fetch_operation_t o, input logic [13:0] j,
                                input logic [13:0] p, input logic v, input logic [15:0] i,
                                input logic [15:0] m, input logic [12:0] a);
        vec_t t;
        t.rst = r; t.op = o; t.ja = j; t.pc = p; t.vld = v; t.inst = i; t.mask = m; t.addr = a;
        return t;
    endfunction

    task automatic clear_mem();
        for (int w = 0; w < 8192; w++) mem[w] = 16'h0000;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rst_sync        = tbl[i].rst;
            fetch_operation = tbl[i].op;
            jump_addr       = tbl[i].ja;
            @(negedge clk);
            chk($sformatf("row%0d pc", i), 32'(pc), 32'(tbl[i].pc));
            chk($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].vld));
            chk($sformatf("row%0d mem_inst_addr", i), 32'(mbus.mem_inst_addr), 32'(tbl[i].addr));
            if (tbl[i].vld)
                chk($sformatf("row%0d inst", i), 32'(inst & tbl[i].mask), 32'(tbl[i].inst & tbl[i].mask));
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_sync = 1'b1; fetch_operation = FETCH_NOP; jump_addr = '0;

        // Segment A: rows 0..7, one-byte then two-byte instruction after reset
        tbl.push_back(mk(1, FETCH_NOP,    0, 0, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(1, FETCH_NOP,    0, 0, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_INC_PC, 0, 0, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_INC_PC, 0, 0, 0, 16'h0000, 16'h0000, 1));
        tbl.push_back(mk(0, FETCH_INC_PC, 0, 0, 1, 16'h0100, 16'h00FF, 1));
        tbl.push_back(mk(0, FETCH_INC_PC, 0, 1, 1, 16'h0201, 16'h00FF, 1));
        tbl.push_back(mk(0, FETCH_INC_PC, 0, 2, 1, 16'h0302, 16'hFFFF, 2));
        tbl.push_back(mk(0, FETCH_INC_PC, 0, 4, 0, 16'h0000, 16'h0000, 3));
        // Segment B: rows 8..13, misaligned two-byte instruction at pc=1
        tbl.push_back(mk(1, FETCH_NOP,    0, 0, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_INC_PC, 0, 0, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_INC_PC, 0, 0, 0, 16'h0000, 16'h0000, 1));
        tbl.push_back(mk(0, FETCH_INC_PC, 0, 0, 1, 16'h0000, 16'h00FF, 1));
        tbl.push_back(mk(0, FETCH_INC_PC, 0, 1, 1, 16'h0002, 16'hFFFF, 1));
        tbl.push_back(mk(0, FETCH_NOP,    0, 3, 1, 16'h0000, 16'h00FF, 2));
        // Segment D: rows 14..19, jump to 5 with a read in flight
        tbl.push_back(mk(1, FETCH_NOP,    0, 0, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_NOP,    0, 0, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_JUMP,   5, 0, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_NOP,    0, 5, 0, 16'h0000, 16'h0000, 2));
        tbl.push_back(mk(0, FETCH_NOP,    0, 5, 0, 16'h0000, 16'h0000, 3));
        tbl.push_back(mk(0, FETCH_NOP,    0, 5, 1, 16'h0010, 16'h00FF, 3));
        // Segment E: rows 20..30, pc wrap at 3FFF then reset mid-fetch
        tbl.push_back(mk(1, FETCH_NOP,    0,        0,        0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_JUMP,   14'h3FFF, 0,        0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_NOP,    0,        14'h3FFF, 0, 16'h0000, 16'h0000, 13'h1FFF));
        tbl.push_back(mk(0, FETCH_NOP,    0,        14'h3FFF, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_NOP,    0,        14'h3FFF, 0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_INC_PC, 0,        14'h3FFF, 1, 16'h7702, 16'hFFFF, 0));
        tbl.push_back(mk(0, FETCH_NOP,    0,        14'h0001, 1, 16'h0000, 16'h00FF, 1));
        tbl.push_back(mk(1, FETCH_INC_PC, 0,        0,        0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_NOP,    0,        0,        0, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, FETCH_NOP,    0,        0,        0, 16'h0000, 16'h0000, 1));
        tbl.push_back(mk(0, FETCH_NOP,    0,        0,        1, 16'h0077, 16'hFFFF, 1));

        clear_mem(); mem[0] = 16'h0100; mem[1] = 16'h0302;
        run_rows(0, 7);
        clear_mem(); mem[0] = 16'h0200; mem[1] = 16'h0000;
        run_rows(8, 13);
        clear_mem(); mem[0] = 16'hFFFF; mem[1] = 16'hFFFF; mem[2] = 16'h10AA;
        run_rows(14, 19);
        clear_mem(); mem[13'h1FFF] = 16'h0200; mem[0] = 16'h0077;
        run_rows(20, 30);

        // Fill the queue with NOPs, then a single 2-byte pop reopens issue.
        clear_mem(); mem[0] = 16'h1102; mem[1] = 16'h3344; mem[2] = 16'h5566;
        rst_sync = 1'b1; fetch_operation = FETCH_NOP; jump_addr = '0;
        idle(1);
        rst_sync = 1'b0;
        idle(6);
        @(negedge clk);
        chk("full count", 32'(dut.count), 32'd4);
        chk("full addr", 32'(mbus.mem_inst_addr), 32'd1);
        chk("full valid", 32'(inst_valid), 32'd1);
        chk("full inst", 32'(inst), 32'h1102);
        @(posedge clk); #1;
        fetch_operation = FETCH_INC_PC;
        idle(1);
        fetch_operation = FETCH_NOP;
        @(negedge clk);
        chk("resume pc", 32'(pc), 32'd2);
        chk("resume addr", 32'(mbus.mem_inst_addr), 32'd2);
        chk("resume inst", 32'(inst[7:0]), 32'h44);
        @(posedge clk); #1;
        idle(2);
        @(negedge clk);
        chk("refill count", 32'(dut.count), 32'd4);
        chk("refill addr", 32'(mbus.mem_inst_addr), 32'd2);
        chk("refill inst", 32'(inst), 32'h3344);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
